// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU result-capture stage.
//   W            datapath word width; a Z entry carries a W-bit hi and a W-bit lo half
//   z_state_t    head-entry read-progress states
//   z_entry_t    one captured result {wide, hi, lo}
//   entry_state  initial head state for a freshly loaded entry
package cpu_pkg;

  localparam int W = 32;

  typedef enum logic [2:0] {
    EMPTY,
    NARROW,
    WIDE,
    WIDE_LO,
    WIDE_HI
  } z_state_t;

  typedef struct packed {
    logic         wide;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } z_entry_t;

  function automatic z_state_t entry_state(input z_entry_t e);
    return e.wide ? WIDE : NARROW;
  endfunction

endpackage

// File: rtl/z_skid_slot.sv
// One-entry holding register behind the Z head.
//   clk, clr_n   clock, async active-low clear
//   load         capture d (only asserted while the slot is empty)
//   unload       hand the entry to the head; slot becomes empty
//   d            entry to capture
//   valid, q     slot occupancy and stored entry
module z_skid_slot
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     clr_n,
  input  logic     load,
  input  logic     unload,
  input  z_entry_t d,
  output logic     valid,
  output z_entry_t q
);

  logic     valid_d, valid_q;
  z_entry_t data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end else if (unload) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/alu_z_stage.sv
// Result-capture stage behind the ALU: holds the current result in the Z
// register pair (head) plus one result in a skid slot, and releases halves
// onto the datapath bus under control-unit read strobes.
//   clk, clr_n        clock, async active-low clear
//   in_valid/in_ready ALU result handshake
//   in_wide, in_data  result width flag and {hi, lo} payload
//   rd_lo, rd_hi      read strobes for ZLO / ZHI
//   bus_out           selected half of the head, 0 when not reading
//   z_valid, z_zero   head occupied / head ZLO is zero
//   rd_err            sticky illegal-read flag
//
// state   | meaning
// EMPTY   | no result held
// NARROW  | 32-bit result, lo still owed
// WIDE    | 64-bit result, both halves owed
// WIDE_LO | lo already read, hi owed
// WIDE_HI | hi already read, lo owed
module alu_z_stage
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           clr_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_wide,
  input  logic [2*W-1:0] in_data,
  input  logic           rd_lo,
  input  logic           rd_hi,
  output logic [W-1:0]   bus_out,
  output logic           z_valid,
  output logic           z_zero,
  output logic           rd_err
);

  z_state_t state_d, state_q;
  z_entry_t head_d, head_q;
  logic     err_d, err_q;

  z_entry_t new_entry;
  z_entry_t skid_q;
  logic     skid_valid;
  logic     skid_load, skid_unload;
  logic     accept, rd_one, legal, do_release;

  assign accept = in_valid && in_ready;
  assign rd_one = rd_lo ^ rd_hi;

  // Narrow results carry hi=0 so a stray hi read returns 0.
  always_comb begin
    new_entry.wide = in_wide;
    new_entry.hi   = in_wide ? in_data[2*W-1:W] : '0;
    new_entry.lo   = in_data[W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    err_d       = err_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    legal       = 1'b0;
    do_release  = 1'b0;

    case (state_q)
      NARROW: begin
        if (rd_one && rd_lo) begin
          legal      = 1'b1;
          do_release = 1'b1;
        end
      end
      WIDE: begin
        if (rd_one) begin
          legal   = 1'b1;
          state_d = rd_lo ? WIDE_LO : WIDE_HI;
        end
      end
      WIDE_LO: begin
        if (rd_one && rd_hi) begin
          legal      = 1'b1;
          do_release = 1'b1;
        end
      end
      WIDE_HI: begin
        if (rd_one && rd_lo) begin
          legal      = 1'b1;
          do_release = 1'b1;
        end
      end
      default: ;
    endcase

    if ((rd_lo || rd_hi) && !legal)
      err_d = 1'b1;

    // accept and a full skid never coincide: in_ready is low while the skid holds data.
    if (do_release) begin
      if (skid_valid) begin
        head_d      = skid_q;
        state_d     = entry_state(skid_q);
        skid_unload = 1'b1;
      end else if (accept) begin
        head_d  = new_entry;
        state_d = entry_state(new_entry);
      end else begin
        head_d  = '0;
        state_d = EMPTY;
      end
    end else if (accept) begin
      if (state_q == EMPTY) begin
        head_d  = new_entry;
        state_d = entry_state(new_entry);
      end else begin
        skid_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      err_q   <= err_d;
    end
  end

  z_skid_slot u_skid (
    .clk    (clk),
    .clr_n  (clr_n),
    .load   (skid_load),
    .unload (skid_unload),
    .d      (new_entry),
    .valid  (skid_valid),
    .q      (skid_q)
  );

  assign in_ready = !skid_valid;
  assign z_valid  = (state_q != EMPTY);
  assign z_zero   = z_valid && (head_q.lo == '0);
  assign rd_err   = err_q;

  // Simultaneous rd_lo and rd_hi favours ZLO.
  always_comb begin
    bus_out = '0;
    if (z_valid) begin
      if (rd_lo)      bus_out = head_q.lo;
      else if (rd_hi) bus_out = head_q.hi;
    end
  end

endmodule

// File: tb/tb_alu_z_stage.sv
module tb_alu_z_stage;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wide = 1'b0;
  logic [63:0] in_data = '0;
  logic        rd_lo = 1'b0;
  logic        rd_hi = 1'b0;
  logic [31:0] bus_out;
  logic        z_valid;
  logic        z_zero;
  logic        rd_err;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: ordered list of held results (index 0 = head) and
  // which halves of the head have already been handed out.
  int          m_n;
  logic        m_wide[2];
  logic [31:0] m_hi[2];
  logic [31:0] m_lo[2];
  logic        lo_done, hi_done;
  logic        m_err;
  logic [31:0] last_bus;

  alu_z_stage dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_wide  (in_wide),
    .in_data  (in_data),
    .rd_lo    (rd_lo),
    .rd_hi    (rd_hi),
    .bus_out  (bus_out),
    .z_valid  (z_valid),
    .z_zero   (z_zero),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_n = 0;
    lo_done = 1'b0;
    hi_done = 1'b0;
    m_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_wide[i] = 1'b0;
      m_hi[i] = '0;
      m_lo[i] = '0;
    end
  endtask

  // One bus cycle: drive inputs at the falling edge, check outputs, advance the model.
  task automatic step(input logic v, input logic w, input logic [63:0] d,
                      input logic rl, input logic rh, input string tag);
    logic        exp_ready, legal, released;
    logic [31:0] exp_bus;
    @(negedge clk);
    in_valid = v; in_wide = w; in_data = d; rd_lo = rl; rd_hi = rh;
    #1;
    exp_ready = (m_n < 2);
    exp_bus = '0;
    if (m_n > 0) begin
      if (rl)      exp_bus = m_lo[0];
      else if (rh) exp_bus = m_hi[0];
    end
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_ready));
    chk({tag, ".z_valid"},  64'(z_valid),  64'(m_n > 0));
    chk({tag, ".z_zero"},   64'(z_zero),   64'(m_n > 0 && m_lo[0] == 32'h0));
    chk({tag, ".rd_err"},   64'(rd_err),   64'(m_err));
    chk({tag, ".bus_out"},  64'(bus_out),  64'(exp_bus));
    last_bus = bus_out;

    released = 1'b0;
    if (rl || rh) begin
      legal = (m_n > 0) && (rl != rh) &&
              (rl ? !lo_done : (m_wide[0] && !hi_done));
      if (!legal) m_err = 1'b1;
      else begin
        if (rl) lo_done = 1'b1; else hi_done = 1'b1;
        if (lo_done && (hi_done || !m_wide[0])) released = 1'b1;
      end
    end
    if (released) begin
      m_wide[0] = m_wide[1]; m_hi[0] = m_hi[1]; m_lo[0] = m_lo[1];
      m_n--;
      lo_done = 1'b0;
      hi_done = 1'b0;
    end
    if (v && exp_ready) begin
      m_wide[m_n] = w;
      m_hi[m_n]   = w ? d[63:32] : 32'h0;
      m_lo[m_n]   = d[31:0];
      m_n++;
    end
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, tag);
  endtask

  // Assert clear between edges and check the outputs before the next edge.
  task automatic mid_reset(input string tag);
    @(posedge clk);
    #2;
    in_valid = 1'b1; rd_lo = 1'b1; rd_hi = 1'b0;
    clr_n = 1'b0;
    #1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".z_valid"},  64'(z_valid),  64'd0);
    chk({tag, ".z_zero"},   64'(z_zero),   64'd0);
    chk({tag, ".rd_err"},   64'(rd_err),   64'd0);
    chk({tag, ".bus_out"},  64'(bus_out),  64'd0);
    model_clear();
    @(negedge clk);
    in_valid = 1'b0; rd_lo = 1'b0;
    clr_n = 1'b1;
  endtask

  initial begin
    logic        v, w, rl, rh;
    logic [63:0] d;
    model_clear();
    last_bus = '0;

    // Power-on reset
    #12;
    chk("por.in_ready", 64'(in_ready), 64'd1);
    chk("por.z_valid",  64'(z_valid),  64'd0);
    chk("por.bus_out",  64'(bus_out),  64'd0);
    @(negedge clk);
    clr_n = 1'b1;

    // Narrow result
    step(1'b1, 1'b0, 64'h0000_0000_8000_0001, 1'b0, 1'b0, "nar.push");
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, "nar.rd");
    chk("nar.bus_val", 64'(last_bus), 64'h8000_0001);
    idle("nar.after");
    chk("nar.released", 64'(z_valid), 64'd0);

    // Wide result, hi then lo
    step(1'b1, 1'b1, 64'h0000_0002_FFFF_FFFE, 1'b0, 1'b0, "wid.push");
    step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, "wid.rdhi");
    chk("wid.hi_val", 64'(last_bus), 64'h0000_0002);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, "wid.rdlo");
    chk("wid.lo_val", 64'(last_bus), 64'hFFFF_FFFE);
    idle("wid.after");

    // Backpressure
    step(1'b1, 1'b0, 64'h11, 1'b0, 1'b0, "bp.p1");
    step(1'b1, 1'b0, 64'h22, 1'b0, 1'b0, "bp.p2");
    step(1'b1, 1'b0, 64'h33, 1'b0, 1'b0, "bp.p3held");
    chk("bp.not_ready", 64'(in_ready), 64'd0);
    step(1'b1, 1'b0, 64'h33, 1'b1, 1'b0, "bp.rd1");
    chk("bp.rd1_val", 64'(last_bus), 64'h11);
    step(1'b1, 1'b0, 64'h33, 1'b0, 1'b0, "bp.p3acc");
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, "bp.rd2");
    chk("bp.rd2_val", 64'(last_bus), 64'h22);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, "bp.rd3");
    chk("bp.rd3_val", 64'(last_bus), 64'h33);
    idle("bp.after");

    // Bypass: release and accept in the same cycle
    step(1'b1, 1'b0, 64'h55, 1'b0, 1'b0, "byp.p1");
    step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, "byp.rdpush");
    idle("byp.after");
    chk("byp.z_zero", 64'(z_zero), 64'd1);
    chk("byp.ready",  64'(in_ready), 64'd1);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, "byp.rd");
    idle("byp.empty");

    // Reset mid-traffic with both entries held
    step(1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 1'b0, "rst.p1");
    step(1'b1, 1'b0, 64'h77, 1'b0, 1'b1, "rst.p2");
    mid_reset("rst.mid");
    idle("rst.after");

    // Errors: empty read, dual read, hi read on narrow
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, "err.empty");
    idle("err.e1");
    chk("err.sticky1", 64'(rd_err), 64'd1);
    step(1'b1, 1'b0, 64'h1234_5678_0000_0009, 1'b0, 1'b0, "err.push");
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, "err.both");
    chk("err.both_bus", 64'(last_bus), 64'h9);
    step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, "err.hinar");
    chk("err.hinar_bus", 64'(last_bus), 64'h0);
    idle("err.held");
    chk("err.still_valid", 64'(z_valid), 64'd1);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, "err.rdok");
    idle("err.after");
    chk("err.sticky2", 64'(rd_err), 64'd1);

    // Randomized traffic, mostly legal reads, with a mid-run reset
    mid_reset("rnd.rst0");
    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset("rnd.rst1");
      v = ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 1) == 1);
      d = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) d[31:0] = 32'h0;
      rl = 1'b0; rh = 1'b0;
      if (m_n > 0 && $urandom_range(0, 9) < 6) begin
        if (!lo_done && (!m_wide[0] || hi_done || $urandom_range(0, 1) == 1)) rl = 1'b1;
        else rh = 1'b1;
      end else if ($urandom_range(0, 19) == 0) begin
        rl = ($urandom_range(0, 1) == 1);
        rh = ($urandom_range(0, 1) == 1);
      end
      step(v, w, d, rl, rh, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
